// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : Iterative multiply/divide unit for the E stage. It executes
//             MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency, executes
//             MTHI/MTLO in one cycle, and owns the architectural HI/LO
//             registers.
//  Ports    : clk        - clock, rising edge
//             reset      - synchronous, active-high
//             i_start    - E-stage instruction is an MD op
//             i_mdop     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                          6 MADD, 7 MSUB (6/7 only with MD_UNIT_MAC_EN)
//             i_a, i_b   - rs / rt operands
//             o_busy     - operation in flight (registered)
//             o_hi, o_lo - architectural HI / LO (registered)
//  Config   : MD_UNIT_MAC_EN - when defined, adds MADD/MSUB on HI/LO
//  Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [2:0]  i_mdop,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
`ifdef MD_UNIT_MAC_EN
    localparam logic [2:0] c_OP_MADD  = 3'd6;
    localparam logic [2:0] c_OP_MSUB  = 3'd7;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_nx;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;
    logic                 r_pend_wr;
    logic [31:0]          w_pend_hi_nx;
    logic [31:0]          w_pend_lo_nx;
    logic                 w_pend_wr_nx;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          w_hi_nx;
    logic [31:0]          w_lo_nx;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic signed [63:0]   w_prod_s;
    logic [63:0]          w_prod_u;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide is done on magnitudes and the signs re-applied, which
    // yields truncation toward zero and handles 0x80000000 / -1 without
    // relying on the simulator's behaviour for signed overflow.
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_b_zero;

    assign w_div_signed = (i_mdop == c_OP_DIV);
    assign w_a_neg      = w_div_signed & i_a[31];
    assign w_b_neg      = w_div_signed & i_b[31];
    assign w_ua         = w_a_neg ? (-i_a) : i_a;
    assign w_ub         = w_b_neg ? (-i_b) : i_b;
    assign w_b_zero     = (i_b == 32'd0);
    assign w_uq         = w_b_zero ? 32'd0 : (w_ua / w_ub);
    assign w_ur         = w_b_zero ? 32'd0 : (w_ua % w_ub);
    assign w_quo        = (w_a_neg ^ w_b_neg) ? (-w_uq) : w_uq;
    assign w_rem        = w_a_neg ? (-w_ur) : w_ur;

    // Completion edge: the pending result commits and a new op may be
    // accepted on that same edge.
    logic        w_done;
    logic        w_accept;
    logic [31:0] w_base_hi;
    logic [31:0] w_base_lo;

    assign w_done    = (r_state == S_RUN) && (r_count == c_CNT_W'(1));
    assign w_accept  = (r_state == S_IDLE) || w_done;
    // HI/LO as they will stand after this edge's commit (accumulator base
    // and the value retained by MTHI/MTLO on a back-to-back edge).
    assign w_base_hi = (w_done && r_pend_wr) ? r_pend_hi : r_hi;
    assign w_base_lo = (w_done && r_pend_wr) ? r_pend_lo : r_lo;

`ifdef MD_UNIT_MAC_EN
    logic [63:0] w_mac_add;
    logic [63:0] w_mac_sub;
    assign w_mac_add = {w_base_hi, w_base_lo} + w_prod_s;
    assign w_mac_sub = {w_base_hi, w_base_lo} - w_prod_s;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx   = r_state;
        w_count_nx   = r_count;
        w_pend_hi_nx = r_pend_hi;
        w_pend_lo_nx = r_pend_lo;
        w_pend_wr_nx = r_pend_wr;
        w_hi_nx      = r_hi;
        w_lo_nx      = r_lo;

        if (r_state == S_RUN) begin
            w_count_nx = r_count - c_CNT_W'(1);
            if (w_done) begin
                w_state_nx   = S_IDLE;
                w_hi_nx      = w_base_hi;
                w_lo_nx      = w_base_lo;
                w_pend_wr_nx = 1'b0;
            end
        end

        if (w_accept && i_start) begin
            case (i_mdop)
                c_OP_MULT: begin
                    {w_pend_hi_nx, w_pend_lo_nx} = w_prod_s;
                    w_pend_wr_nx = 1'b1;
                    w_count_nx   = c_CNT_W'(MULT_CYCLES);
                    w_state_nx   = S_RUN;
                end
                c_OP_MULTU: begin
                    {w_pend_hi_nx, w_pend_lo_nx} = w_prod_u;
                    w_pend_wr_nx = 1'b1;
                    w_count_nx   = c_CNT_W'(MULT_CYCLES);
                    w_state_nx   = S_RUN;
                end
                c_OP_DIV, c_OP_DIVU: begin
                    w_pend_hi_nx = w_rem;
                    w_pend_lo_nx = w_quo;
                    // Divide by zero still takes the full latency but
                    // leaves HI/LO untouched.
                    w_pend_wr_nx = ~w_b_zero;
                    w_count_nx   = c_CNT_W'(DIV_CYCLES);
                    w_state_nx   = S_RUN;
                end
                c_OP_MTHI: begin
                    w_hi_nx = i_a;
                end
                c_OP_MTLO: begin
                    w_lo_nx = i_a;
                end
`ifdef MD_UNIT_MAC_EN
                c_OP_MADD: begin
                    {w_pend_hi_nx, w_pend_lo_nx} = w_mac_add;
                    w_pend_wr_nx = 1'b1;
                    w_count_nx   = c_CNT_W'(MULT_CYCLES);
                    w_state_nx   = S_RUN;
                end
                c_OP_MSUB: begin
                    {w_pend_hi_nx, w_pend_lo_nx} = w_mac_sub;
                    w_pend_wr_nx = 1'b1;
                    w_count_nx   = c_CNT_W'(MULT_CYCLES);
                    w_state_nx   = S_RUN;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_pend_hi <= w_pend_hi_nx;
            r_pend_lo <= w_pend_lo_nx;
            r_pend_wr <= w_pend_wr_nx;
            r_hi      <= w_hi_nx;
            r_lo      <= w_lo_nx;
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Purpose  : Self-checking bench for md_unit. Expected results are queued
//             when an op is issued and compared when the unit finishes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (start),
        .i_mdop  (mdop),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] eh, input logic [31:0] el,
                            input int cyc);
        exp_t e;
        e.tag = tag;
        e.hi  = eh;
        e.lo  = el;
        e.cyc = cyc;
        sb.push_back(e);
        pre_hi = hi;
        pre_lo = lo;
    endtask

    // One-cycle start pulse; returns at the negedge after the sampling edge.
    task automatic pulse(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input string tag, input logic [31:0] eh, input logic [31:0] el,
                         input int cyc);
        push_exp(tag, eh, el, cyc);
        pulse(op, va, vb);
    endtask

    // Count busy cycles, optionally inject a start on busy cycle inj_at,
    // then pop and compare the oldest expectation.
    task automatic wait_done(input int inj_at, input logic [2:0] iop, input logic [31:0] ia);
        exp_t e;
        int   cnt;
        bit   moved;
        cnt   = 0;
        moved = 1'b0;
        while (busy && cnt < 200) begin
            cnt++;
            if (hi !== pre_hi || lo !== pre_lo) moved = 1'b1;
            if (cnt == inj_at) begin
                start = 1'b1;
                mdop  = iop;
                a     = ia;
            end
            @(negedge clk);
            start = 1'b0;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_cycles"}, 64'(cnt), 64'(e.cyc));
            chk({e.tag, "_stable"}, 64'(moved), 64'd0);
            chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mdop  = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        issue(3'd0, 32'hFFFFFFFE, 32'd3, "mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        wait_done(0, 3'd0, 32'd0);
        issue(3'd1, 32'hFFFFFFFE, 32'd3, "multu", 32'h00000002, 32'hFFFFFFFA, 5);
        wait_done(0, 3'd0, 32'd0);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, "div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        wait_done(0, 3'd0, 32'd0);
        issue(3'd3, 32'd7, 32'd2, "divu", 32'd1, 32'd3, 10);
        wait_done(0, 3'd0, 32'd0);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 32'd0, 32'h80000000, 10);
        wait_done(0, 3'd0, 32'd0);
        issue(3'd2, 32'd7, 32'hFFFFFFFE, "div_negb", 32'd1, 32'hFFFFFFFD, 10);
        wait_done(0, 3'd0, 32'd0);

        // MTHI in IDLE: one-edge latency, LO untouched.
        pulse(3'd4, 32'h12345678, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h12345678);
        chk("mthi_lo", 64'(lo), 64'hFFFFFFFD);
        chk("mthi_busy", 64'(busy), 64'd0);

        // Divide by zero leaves HI/LO as they were.
        issue(3'd3, 32'd55, 32'd0, "divu_zero", 32'h12345678, 32'hFFFFFFFD, 10);
        wait_done(0, 3'd0, 32'd0);

        pulse(3'd5, 32'hCAFEF00D, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'hCAFEF00D);
        chk("mtlo_hi", 64'(hi), 64'h12345678);

        // MTLO pulsed on busy cycle 2 must be ignored.
        issue(3'd0, 32'd1000, 32'hFFFFFFFF, "mult_ign", 32'hFFFFFFFF, 32'hFFFFFC18, 5);
        wait_done(2, 3'd5, 32'hDEADBEEF);

        // Back-to-back: DIVU started on the MULTU completion edge.
        issue(3'd1, 32'd2, 32'd3, "multu_b2b", 32'd0, 32'd6, 5);
        repeat (4) @(negedge clk);
        chk("b2b_busy_pre", 64'(busy), 64'd1);
        start = 1'b1;
        mdop  = 3'd3;
        a     = 32'd9;
        b     = 32'd4;
        @(negedge clk);
        start = 1'b0;
        begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
        end
        chk("b2b_busy_gap", 64'(busy), 64'd1);
        push_exp("divu_b2b", 32'd1, 32'd2, 10);
        wait_done(0, 3'd0, 32'd0);

        // Reset on busy cycle 3 of a DIV discards it.
        pulse(3'd2, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_run_busy", 64'(busy), 64'd0);
        chk("rst_run_hi", 64'(hi), 64'd0);
        chk("rst_run_lo", 64'(lo), 64'd0);
        repeat (12) @(negedge clk);
        chk("rst_late_busy", 64'(busy), 64'd0);
        chk("rst_late_hilo", {hi, lo}, 64'd0);

        // Reset beats start on the same edge.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        mdop  = 3'd4;
        a     = 32'h5A5A5A5A;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_prio_hi", 64'(hi), 64'd0);
        chk("rst_prio_busy", 64'(busy), 64'd0);

`ifdef MD_UNIT_MAC_EN
        pulse(3'd4, 32'd0, 32'd0);
        pulse(3'd5, 32'd10, 32'd0);
        issue(3'd6, 32'd3, 32'd4, "madd", 32'd0, 32'd22, 5);
        wait_done(0, 3'd0, 32'd0);
        issue(3'd7, 32'd5, 32'd5, "msub", 32'hFFFFFFFF, 32'hFFFFFFFD, 5);
        wait_done(0, 3'd0, 32'd0);
`else
        pulse(3'd4, 32'h0000BEEF, 32'd0);
        pulse(3'd6, 32'd3, 32'd4);
        chk("undef6_busy", 64'(busy), 64'd0);
        chk("undef6_hilo", {hi, lo}, {32'h0000BEEF, 32'd0});
        pulse(3'd7, 32'd5, 32'd5);
        chk("undef7_busy", 64'(busy), 64'd0);
        chk("undef7_hilo", {hi, lo}, {32'h0000BEEF, 32'd0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
